// File: rtl/vga_patt_sel.sv
// vga_patt_sel: picks one of NUM_PATT pattern-generator colour channels for the
// VGA driver. The selection comes from debounced switches (manual mode) or
// from a frame counter (auto mode), and only changes at a frame boundary.
module vga_patt_sel #(
  parameter int   NUM_PATT    = 4,
  parameter int   RGB_W       = 3,
  parameter int   DEB_CYC     = 500000,
  parameter int   AUTO_FRAMES = 120,
  parameter logic VSYNC_POL   = 1'b0,
  localparam int  SEL_W       = (NUM_PATT > 2) ? $clog2(NUM_PATT) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      auto_i,
  input  logic                      vSync_i,
  input  logic [NUM_PATT*RGB_W-1:0] rgb_i,
  output logic [RGB_W-1:0]          rgb_o,
  output logic [SEL_W-1:0]          active_sel_o,
  output logic                      switch_o
);

  localparam int DEB_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam int FRM_W = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(AUTO_FRAMES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATT - 1);
  localparam logic [SEL_W:0]   NUM_PATT_C = (SEL_W + 1)'(NUM_PATT);

  // Debounce state: candidate, stability counter and accepted value per input.
  logic [SEL_W-1:0] r_sel_cand, r_sel_stable;
  logic [DEB_W-1:0] r_sel_cnt;
  logic             r_auto_cand, r_auto_stable;
  logic [DEB_W-1:0] r_auto_cnt;

  // Frame tracking and selection state.
  logic             r_vs_prev;
  logic             r_started;
  logic [FRM_W-1:0] r_frame_cnt;
  logic [SEL_W-1:0] r_active_sel;
  logic             r_switch;
  logic [RGB_W-1:0] r_rgb;

  logic             w_frame_start;
  logic [SEL_W-1:0] w_next_sel;
  logic [FRM_W-1:0] w_next_frame_cnt;
  logic [RGB_W-1:0] w_chan_rgb;

  // Debounce the select switches: restart the window whenever the raw value moves.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values; this is what lets a frame start in the same cycle as
    // a debounce update act on the old stable value.
    if (!reset_ni) begin
      r_sel_cand   <= '0;
      r_sel_cnt    <= '0;
      r_sel_stable <= '0;
    end else if (sel_i != r_sel_cand) begin
      r_sel_cand <= sel_i;
      r_sel_cnt  <= '0;
    end else if (r_sel_cnt == DEB_LAST) begin
      r_sel_stable <= r_sel_cand;
    end else begin
      r_sel_cnt <= r_sel_cnt + 1'b1;
    end
  end

  // Debounce the auto-mode switch the same way.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_auto_cand   <= 1'b0;
      r_auto_cnt    <= '0;
      r_auto_stable <= 1'b0;
    end else if (auto_i != r_auto_cand) begin
      r_auto_cand <= auto_i;
      r_auto_cnt  <= '0;
    end else if (r_auto_cnt == DEB_LAST) begin
      r_auto_stable <= r_auto_cand;
    end else begin
      r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end

  // Track the previous vSync level; r_started masks the first cycle out of
  // reset so an already-active vSync is not mistaken for a new frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vs_prev <= ~VSYNC_POL;
      r_started <= 1'b0;
    end else begin
      r_vs_prev <= vSync_i;
      r_started <= 1'b1;
    end
  end

  assign w_frame_start = r_started && (r_vs_prev != VSYNC_POL) && (vSync_i == VSYNC_POL);

  // Next selection and frame count: manual load or auto advance, only at frame start.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_sel       = r_active_sel;
    w_next_frame_cnt = r_frame_cnt;
    if (!r_auto_stable) begin
      w_next_frame_cnt = '0;
      if (w_frame_start && ({1'b0, r_sel_stable} < NUM_PATT_C)) begin
        w_next_sel = r_sel_stable;
      end
    end else if (w_frame_start) begin
      if (r_frame_cnt == FRM_LAST) begin
        w_next_frame_cnt = '0;
        w_next_sel       = (r_active_sel == SEL_LAST) ? '0 : r_active_sel + 1'b1;
      end else begin
        w_next_frame_cnt = r_frame_cnt + 1'b1;
      end
    end
  end

  // Register the selection and pulse switch_o only when the index actually changes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_active_sel <= '0;
      r_frame_cnt  <= '0;
      r_switch     <= 1'b0;
    end else begin
      r_active_sel <= w_next_sel;
      r_frame_cnt  <= w_next_frame_cnt;
      r_switch     <= (w_next_sel != r_active_sel);
    end
  end

  // Channel mux driven by the registered index, which is always < NUM_PATT.
  always_comb begin
    w_chan_rgb = '0;
    for (int k = 0; k < NUM_PATT; k++) begin
      if (r_active_sel == SEL_W'(k)) begin
        w_chan_rgb = rgb_i[k*RGB_W +: RGB_W];
      end
    end
  end

  // Register the selected colour toward the driver.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_chan_rgb;
    end
  end

  assign rgb_o        = r_rgb;
  assign active_sel_o = r_active_sel;
  assign switch_o     = r_switch;

endmodule

// File: tb/tb_vga_patt_sel.sv
// Directed bench for vga_patt_sel with a short debounce window and two
// frames per auto step. Inputs are driven and outputs sampled on the falling
// clock edge, half a period away from the rising edge the design uses.
module tb_vga_patt_sel;

  localparam int   NUM_PATT    = 4;
  localparam int   RGB_W       = 3;
  localparam int   DEB_CYC     = 4;
  localparam int   AUTO_FRAMES = 2;
  localparam logic VSYNC_POL   = 1'b0;
  localparam int   SEL_W       = 2;

  logic                      clk = 1'b0;
  logic                      reset_ni;
  logic [SEL_W-1:0]          sel_i;
  logic                      auto_i;
  logic                      vSync_i;
  logic [NUM_PATT*RGB_W-1:0] rgb_i;
  logic [RGB_W-1:0]          rgb_o;
  logic [SEL_W-1:0]          active_sel_o;
  logic                      switch_o;

  int checks = 0;
  int errors = 0;

  vga_patt_sel #(
    .NUM_PATT   (NUM_PATT),
    .RGB_W      (RGB_W),
    .DEB_CYC    (DEB_CYC),
    .AUTO_FRAMES(AUTO_FRAMES),
    .VSYNC_POL  (VSYNC_POL)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .sel_i       (sel_i),
    .auto_i      (auto_i),
    .vSync_i     (vSync_i),
    .rgb_i       (rgb_i),
    .rgb_o       (rgb_o),
    .active_sel_o(active_sel_o),
    .switch_o    (switch_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Active vSync edge; returns after the rising clock edge that sees it.
  task automatic vs_fall();
    vSync_i = 1'b0;
    tick(1);
  endtask

  task automatic vs_rise();
    vSync_i = 1'b1;
    tick(1);
  endtask

  initial begin
    automatic logic [SEL_W-1:0] auto_seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    reset_ni = 1'b0;
    sel_i    = '0;
    auto_i   = 1'b0;
    vSync_i  = 1'b1;
    rgb_i    = {3'b100, 3'b010, 3'b001, 3'b111};

    // Reset state.
    tick(3);
    check("rst_active", 32'(active_sel_o), 32'd0);
    check("rst_switch", 32'(switch_o), 32'd0);
    check("rst_rgb", 32'(rgb_o), 32'd0);
    reset_ni = 1'b1;
    tick(2);
    check("post_rst_rgb", 32'(rgb_o), 32'h7);

    // Bounce reject: sel toggles every 2 clocks with frame starts interleaved.
    for (int i = 0; i < 24; i++) begin
      check("bounce_active", 32'(active_sel_o), 32'd0);
      check("bounce_switch", 32'(switch_o), 32'd0);
      sel_i   = (((i / 2) % 2) == 0) ? 2'd1 : 2'd0;
      vSync_i = ((i % 6) == 3) ? 1'b0 : 1'b1;
      tick(1);
    end
    vSync_i = 1'b1;
    sel_i   = 2'd0;
    tick(6);

    // No mid-frame switch: stable sel=3 waits for the next frame start.
    sel_i = 2'd3;
    tick(50);
    check("midframe_active_50", 32'(active_sel_o), 32'd0);
    tick(50);
    check("midframe_active_100", 32'(active_sel_o), 32'd0);
    vs_fall();
    check("frame3_active", 32'(active_sel_o), 32'd3);
    check("frame3_switch", 32'(switch_o), 32'd1);
    check("frame3_rgb_old", 32'(rgb_o), 32'h7);
    vs_rise();
    check("frame3_rgb_new", 32'(rgb_o), 32'h4);
    check("frame3_switch_end", 32'(switch_o), 32'd0);

    // Manual switch to channel 2.
    sel_i = 2'd2;
    tick(10);
    vs_fall();
    check("man2_active", 32'(active_sel_o), 32'd2);
    check("man2_switch", 32'(switch_o), 32'd1);
    check("man2_rgb_old", 32'(rgb_o), 32'h4);
    vs_rise();
    check("man2_rgb_new", 32'(rgb_o), 32'h2);
    check("man2_switch_end", 32'(switch_o), 32'd0);
    check("man2_active_hold", 32'(active_sel_o), 32'd2);

    // Simultaneous events: stable sel becomes 1 on the same edge as a frame start.
    sel_i = 2'd1;
    tick(4);
    vs_fall();
    check("simul_active_old", 32'(active_sel_o), 32'd2);
    check("simul_no_pulse", 32'(switch_o), 32'd0);
    vs_rise();
    vs_fall();
    check("simul_active_new", 32'(active_sel_o), 32'd1);
    check("simul_switch", 32'(switch_o), 32'd1);
    vs_rise();

    // Return to channel 0, then enable auto mode.
    sel_i = 2'd0;
    tick(6);
    vs_fall();
    check("back0_active", 32'(active_sel_o), 32'd0);
    vs_rise();
    auto_i = 1'b1;
    tick(6);
    for (int k = 0; k < 8; k++) begin
      vs_fall();
      check("auto_active", 32'(active_sel_o), 32'(auto_seq[k]));
      check("auto_switch", 32'(switch_o), ((k % 2) == 1) ? 32'd1 : 32'd0);
      vs_rise();
      check("auto_switch_end", 32'(switch_o), 32'd0);
    end

    // Advance to channel 3 and one frame into the next auto step.
    for (int k = 0; k < 7; k++) begin
      vs_fall();
      vs_rise();
    end
    check("auto_at3", 32'(active_sel_o), 32'd3);

    // Asynchronous reset mid-clock with vSync already active at release.
    #2 reset_ni = 1'b0;
    #1;
    check("async_rst_active", 32'(active_sel_o), 32'd0);
    check("async_rst_switch", 32'(switch_o), 32'd0);
    check("async_rst_rgb", 32'(rgb_o), 32'd0);
    vSync_i = 1'b0;
    tick(2);
    reset_ni = 1'b1;
    tick(1);
    check("release_active", 32'(active_sel_o), 32'd0);
    check("release_switch", 32'(switch_o), 32'd0);
    check("release_rgb", 32'(rgb_o), 32'h7);

    // Auto progress was discarded: the first frame after re-debounce must not advance.
    vSync_i = 1'b1;
    tick(6);
    vs_fall();
    check("reauto_f1_active", 32'(active_sel_o), 32'd0);
    check("reauto_f1_switch", 32'(switch_o), 32'd0);
    vs_rise();
    vs_fall();
    check("reauto_f2_active", 32'(active_sel_o), 32'd1);
    check("reauto_f2_switch", 32'(switch_o), 32'd1);
    vs_rise();
    check("reauto_f2_rgb", 32'(rgb_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
